// File: rtl/sys_reset_sequencer.sv
// Reset / clock-enable sequencer for the system clock domain.
// Releases NUM_CH reset channels in ascending order once the PLL lock has been stable,
// drains them in descending order on a software request, and re-arms every channel
// at once on lock loss. Per-channel clock enables follow a free-running divider.
module sys_reset_sequencer #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned LOCK_STABLE = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CE_DIV      = 1
) (
    input  logic              sys_clk,
    input  logic              sys_sync_rst,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] ch_rst,
    output logic [NUM_CH-1:0] ch_init,
    output logic [NUM_CH-1:0] ch_clk_en,
    output logic              seq_busy,
    output logic [1:0]        seq_state,
    output logic [7:0]        fault_cnt
);

    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned GapW = $clog2(STAGE_GAP + 1);
    localparam int unsigned StbW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned CeW  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_CH - 1);
    localparam logic [GapW-1:0]   GapEnd   = GapW'(STAGE_GAP - 1);
    localparam logic [StbW-1:0]   StbEnd   = StbW'(LOCK_STABLE - 1);
    localparam logic [CeW-1:0]    CeEnd    = CeW'(CE_DIV - 1);
    localparam logic [NUM_CH-1:0] ChOne    = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] LastMask = ChOne << (NUM_CH - 1);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2,
        StDrain   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [CeW-1:0]         ce_cnt_q;
    logic                   ce_tick;
    logic [NUM_CH-1:0]      ce_mask;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_up;
    logic [IdxW-1:0]   idx_dn;
    logic [GapW-1:0]   gap_q;
    logic [StbW-1:0]   stable_q;
    logic [NUM_CH-1:0] ch_rst_q;
    logic [NUM_CH-1:0] ch_init_q;
    logic [NUM_CH-1:0] ch_clk_en_q;
    logic              seq_busy_q;
    logic [7:0]        fault_q;
    logic [NUM_CH-1:0] up_mask;
    logic [NUM_CH-1:0] dn_mask;
    logic              lock_lost;

    // Lock synchroniser: shift the asynchronous lock through SYNC_STAGES flops.
    always_ff @(posedge sys_clk) begin
        if (sys_sync_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Free-running clock-enable divider; only the system reset restarts it.
    always_ff @(posedge sys_clk) begin
        if (sys_sync_rst || ce_cnt_q == CeEnd) begin
            ce_cnt_q <= '0;
        end else begin
            ce_cnt_q <= ce_cnt_q + CeW'(1);
        end
    end

    // Channel masks for the neighbour of the current index, plus the lock-loss condition.
    always_comb begin
        ce_tick   = (ce_cnt_q == CeEnd);
        ce_mask   = {NUM_CH{ce_tick}};
        idx_up    = idx_q + IdxW'(1);
        idx_dn    = idx_q - IdxW'(1);
        up_mask   = ChOne << idx_up;
        dn_mask   = ChOne << idx_dn;
        lock_lost = !lock_s && (state_q != StHold);
    end

    // Sequencer FSM; enables are computed from the reset value being written this edge so
    // that an enable drops on the same edge its reset rises and skips the init cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_sync_rst) begin
            state_q     <= StHold;
            idx_q       <= '0;
            gap_q       <= '0;
            stable_q    <= '0;
            ch_rst_q    <= '1;
            ch_init_q   <= '0;
            ch_clk_en_q <= '0;
            seq_busy_q  <= 1'b1;
            fault_q     <= '0;
        end else if (lock_lost) begin
            // Lock loss beats any concurrent software request.
            state_q     <= StHold;
            idx_q       <= '0;
            gap_q       <= '0;
            stable_q    <= '0;
            ch_rst_q    <= '1;
            ch_init_q   <= '0;
            ch_clk_en_q <= '0;
            seq_busy_q  <= 1'b1;
            if (fault_q != 8'hFF) begin
                fault_q <= fault_q + 8'd1;
            end
        end else begin
            ch_init_q  <= '0;
            seq_busy_q <= 1'b1;
            unique case (state_q)
                StHold: begin
                    ch_clk_en_q <= '0;
                    if (!lock_s) begin
                        stable_q <= '0;
                    end else if (stable_q == StbEnd) begin
                        state_q   <= StRelease;
                        stable_q  <= '0;
                        idx_q     <= '0;
                        gap_q     <= '0;
                        ch_rst_q  <= ~ChOne;
                        ch_init_q <= ChOne;
                    end else begin
                        stable_q <= stable_q + StbW'(1);
                    end
                end
                StRelease: begin
                    if (sw_rst_req) begin
                        state_q     <= StHold;
                        idx_q       <= '0;
                        gap_q       <= '0;
                        ch_rst_q    <= '1;
                        ch_clk_en_q <= '0;
                    end else if (idx_q == LastIdx) begin
                        state_q     <= StRun;
                        idx_q       <= '0;
                        gap_q       <= '0;
                        seq_busy_q  <= 1'b0;
                        ch_clk_en_q <= ce_mask & ~ch_rst_q;
                    end else if (gap_q == GapEnd) begin
                        idx_q       <= idx_up;
                        gap_q       <= '0;
                        ch_rst_q    <= ch_rst_q & ~up_mask;
                        ch_init_q   <= up_mask;
                        ch_clk_en_q <= ce_mask & ~ch_rst_q;
                    end else begin
                        gap_q       <= gap_q + GapW'(1);
                        ch_clk_en_q <= ce_mask & ~ch_rst_q;
                    end
                end
                StRun: begin
                    if (sw_rst_req) begin
                        state_q     <= StDrain;
                        idx_q       <= LastIdx;
                        gap_q       <= '0;
                        ch_rst_q    <= ch_rst_q | LastMask;
                        ch_clk_en_q <= ce_mask & ~(ch_rst_q | LastMask);
                    end else begin
                        seq_busy_q  <= 1'b0;
                        ch_clk_en_q <= ce_mask & ~ch_rst_q;
                    end
                end
                StDrain: begin
                    if (idx_q == '0) begin
                        state_q     <= StHold;
                        gap_q       <= '0;
                        stable_q    <= '0;
                        ch_clk_en_q <= '0;
                    end else if (gap_q == GapEnd) begin
                        idx_q       <= idx_dn;
                        gap_q       <= '0;
                        ch_rst_q    <= ch_rst_q | dn_mask;
                        ch_clk_en_q <= ce_mask & ~(ch_rst_q | dn_mask);
                    end else begin
                        gap_q       <= gap_q + GapW'(1);
                        ch_clk_en_q <= ce_mask & ~ch_rst_q;
                    end
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign ch_rst    = ch_rst_q;
    assign ch_init   = ch_init_q;
    assign ch_clk_en = ch_clk_en_q;
    assign seq_busy  = seq_busy_q;
    assign seq_state = state_q;
    assign fault_cnt = fault_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Directed bench for sys_reset_sequencer: default instance plus a NUM_CH=2 / CE_DIV=3 one.
module tb_sys_reset_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_sync_rst;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [3:0] ch_rst, ch_init, ch_clk_en;
    logic       seq_busy;
    logic [1:0] seq_state;
    logic [7:0] fault_cnt;
    logic [1:0] b_rst, b_init, b_en;
    logic       b_busy;
    logic [1:0] b_state;
    logic [7:0] b_fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    sys_reset_sequencer dut (
        .sys_clk      (sys_clk),
        .sys_sync_rst (sys_sync_rst),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .ch_rst       (ch_rst),
        .ch_init      (ch_init),
        .ch_clk_en    (ch_clk_en),
        .seq_busy     (seq_busy),
        .seq_state    (seq_state),
        .fault_cnt    (fault_cnt)
    );

    sys_reset_sequencer #(.NUM_CH(2), .CE_DIV(3)) dut_b (
        .sys_clk      (sys_clk),
        .sys_sync_rst (sys_sync_rst),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .ch_rst       (b_rst),
        .ch_init      (b_init),
        .ch_clk_en    (b_en),
        .seq_busy     (b_busy),
        .seq_state    (b_state),
        .fault_cnt    (b_fault)
    );

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Hold reset for three edges; the edge after return is edge 1.
    task automatic apply_reset();
        sys_sync_rst = 1'b1;
        pll_locked   = 1'b1;
        sw_rst_req   = 1'b0;
        repeat (3) tick();
        sys_sync_rst = 1'b0;
    endtask

    // Expected {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} for the default instance
    // n edges after entering HOLD with lock stable, first release at edge t0.
    function automatic logic [14:0] exp_seq(int n, int t0);
        logic [3:0] er, ei, ee;
        logic [1:0] es;
        for (int k = 0; k < 4; k++) begin
            er[k] = (n < t0 + 4 * k);
            ei[k] = (n == t0 + 4 * k);
        end
        ee = ~er & ~ei;
        es = (n < t0) ? 2'd0 : (n < t0 + 13) ? 2'd1 : 2'd2;
        return {er, ei, ee, es, (es != 2'd2)};
    endfunction

    task automatic test_reset();
        sys_sync_rst = 1'b1;
        pll_locked   = 1'b1;
        sw_rst_req   = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== 15'b1111_0000_0000_00_1) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b",
                     {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, 15'b1111_0000_0000_00_1);
        end
        n_cmp++;
        if (fault_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_fault: got %0d want 0", fault_cnt);
        end
        n_cmp++;
        if ({b_rst, b_init, b_en, b_state, b_busy} !== 9'b11_00_00_00_1) begin
            n_err++;
            $display("FAIL reset_outputs_b: got %b want %b",
                     {b_rst, b_init, b_en, b_state, b_busy}, 9'b11_00_00_00_1);
        end
        n_cmp++;
        if (b_fault !== 8'd0) begin
            n_err++;
            $display("FAIL reset_fault_b: got %0d want 0", b_fault);
        end
        sw_rst_req   = 1'b0;
        sys_sync_rst = 1'b0;
    endtask

    task automatic test_startup();
        logic [1:0] br, bi, be, bs;
        for (int n = 1; n <= 26; n++) begin
            tick();
            n_cmp++;
            if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== exp_seq(n, 10)) begin
                n_err++;
                $display("FAIL startup edge %0d: got %b want %b", n,
                         {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, exp_seq(n, 10));
            end
            for (int k = 0; k < 2; k++) begin
                br[k] = (n < 10 + 4 * k);
                bi[k] = (n == 10 + 4 * k);
                be[k] = ((n % 3) == 0) && (n >= 11 + 4 * k);
            end
            bs = (n < 10) ? 2'd0 : (n < 15) ? 2'd1 : 2'd2;
            n_cmp++;
            if ({b_rst, b_init, b_en, b_state, b_busy} !== {br, bi, be, bs, (bs != 2'd2)}) begin
                n_err++;
                $display("FAIL startup_ce_div edge %0d: got %b want %b", n,
                         {b_rst, b_init, b_en, b_state, b_busy}, {br, bi, be, bs, (bs != 2'd2)});
            end
        end
        n_cmp++;
        if (fault_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL startup_fault: got %0d want 0", fault_cnt);
        end
    endtask

    // One-cycle PLL drop in RUN: response two edges after it is first sampled.
    task automatic test_lock_glitch();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        n_cmp++;
        if ({ch_rst, seq_state} !== {4'h0, 2'd2}) begin
            n_err++;
            $display("FAIL glitch_early: got %b want %b", {ch_rst, seq_state}, {4'h0, 2'd2});
        end
        for (int j = 0; j <= 21; j++) begin
            tick();
            n_cmp++;
            if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== exp_seq(j, 8)) begin
                n_err++;
                $display("FAIL glitch edge +%0d: got %b want %b", j,
                         {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, exp_seq(j, 8));
            end
        end
        n_cmp++;
        if (fault_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL glitch_fault: got %0d want 1", fault_cnt);
        end
    endtask

    // Software drain from RUN, then automatic re-release.
    task automatic test_sw_drain();
        logic [3:0] er, ei, ee;
        logic [1:0] es;
        sw_rst_req = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            tick();
            sw_rst_req = 1'b0;
            for (int k = 0; k < 4; k++) begin
                er[k] = (j >= 1 + 4 * (3 - k)) && (j < 22 + 4 * k);
                ei[k] = (j == 22 + 4 * k);
            end
            ee = ~er & ~ei;
            es = (j <= 13) ? 2'd3 : (j <= 21) ? 2'd0 : (j <= 34) ? 2'd1 : 2'd2;
            n_cmp++;
            if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !==
                {er, ei, ee, es, (es != 2'd2)}) begin
                n_err++;
                $display("FAIL drain edge +%0d: got %b want %b", j,
                         {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy},
                         {er, ei, ee, es, (es != 2'd2)});
            end
        end
        n_cmp++;
        if (fault_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL drain_fault: got %0d want 1", fault_cnt);
        end
    endtask

    // Software request on the same edge that sees lock loss: no drain, fault counted.
    task automatic test_coincident();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        n_cmp++;
        if ({ch_rst, seq_state} !== {4'h0, 2'd2}) begin
            n_err++;
            $display("FAIL coinc_early: got %b want %b", {ch_rst, seq_state}, {4'h0, 2'd2});
        end
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n_cmp++;
        if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== 15'b1111_0000_0000_00_1) begin
            n_err++;
            $display("FAIL coinc_assert: got %b want %b",
                     {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, 15'b1111_0000_0000_00_1);
        end
        n_cmp++;
        if (fault_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL coinc_fault: got %0d want 2", fault_cnt);
        end
        tick();
        n_cmp++;
        if ({ch_rst, seq_state} !== {4'hF, 2'd0}) begin
            n_err++;
            $display("FAIL coinc_after: got %b want %b", {ch_rst, seq_state}, {4'hF, 2'd0});
        end
    endtask

    // Lock drop while the stable count is 5 restarts the count; no fault in HOLD.
    task automatic test_stable_restart();
        apply_reset();
        for (int n = 1; n <= 29; n++) begin
            tick();
            n_cmp++;
            if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== exp_seq(n, 16)) begin
                n_err++;
                $display("FAIL stable_restart edge %0d: got %b want %b", n,
                         {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, exp_seq(n, 16));
            end
            if (n == 5) pll_locked = 1'b0;
            if (n == 6) pll_locked = 1'b1;
        end
        n_cmp++;
        if (fault_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL stable_restart_fault: got %0d want 0", fault_cnt);
        end
    endtask

    // Software request in RELEASE aborts straight to HOLD, then releases again.
    task automatic test_release_abort();
        int t0;
        apply_reset();
        for (int n = 1; n <= 42; n++) begin
            tick();
            sw_rst_req = (n == 20);
            t0 = (n <= 20) ? 10 : 29;
            n_cmp++;
            if ({ch_rst, ch_init, ch_clk_en, seq_state, seq_busy} !== exp_seq(n, t0)) begin
                n_err++;
                $display("FAIL release_abort edge %0d: got %b want %b", n,
                         {ch_rst, ch_init, ch_clk_en, seq_state, seq_busy}, exp_seq(n, t0));
            end
        end
        n_cmp++;
        if (fault_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL release_abort_fault: got %0d want 0", fault_cnt);
        end
    endtask

    // Repeated lock losses saturate the fault counter at 255.
    task automatic test_fault_saturation();
        int exp_f = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            tick();
            tick();
            exp_f = (exp_f == 255) ? 255 : exp_f + 1;
            n_cmp++;
            if (fault_cnt !== 8'(exp_f) || seq_state !== 2'd0) begin
                n_err++;
                $display("FAIL fault_sat iter %0d: got fault %0d state %0d want %0d state 0",
                         i, fault_cnt, seq_state, exp_f);
            end
            for (int w = 0; w < 40 && seq_state !== 2'd1; w++) tick();
            n_cmp++;
            if (seq_state !== 2'd1) begin
                n_err++;
                $display("FAIL fault_sat_wait iter %0d: got state %0d want 1", i, seq_state);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_lock_glitch();
        test_sw_drain();
        test_coincident();
        test_stable_restart();
        test_release_abort();
        test_fault_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
